seg7_display: RTL and testbench



---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_bcd_conv.sv | 101 ++++++++++
 rtl/seg7_display.sv | 146 ++++++++++++++
 tb/tb_seg7_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam seg_t SEG_OFF  = 8'hFF;
  localparam seg_t SEG_DASH = 8'hBF;
  localparam int   DP_BIT   = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  // Non-decimal nibbles show as blank rather than garbage.
  function automatic seg_t seg_decode(input logic [3:0] nibble);
    if (nibble > 4'd9) begin
      return SEG_OFF;
    end
    return SEG_DIGIT[nibble];
  endfunction

  // 10**n, wide enough for n up to 9 plus margin.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | ready_o=1, waits for start_i
//   SHIFT | VAL_W cycles of add-3 then shift-left
//   LATCH | one cycle, done_o=1, bcd_o holds the final result
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start_i     : begin a conversion (only honoured in IDLE)
//   value_i     : binary input, captured with start_i
//   ready_o     : converter idle (registered)
//   done_o      : high during LATCH (registered)
//   bcd_o       : BCD result, 4 bits per digit, digit 0 in bits [3:0]
module seg7_bcd_conv
  import seg7_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int VAL_W  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [VAL_W-1:0]      value_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(VAL_W - 1);

  state_e             state_q;
  logic [VAL_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               done_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            bin_q   <= value_i;
            bcd_q   <= '0;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Bits leaving the top nibble are dropped; only an overflowing
          // value produces them and the top level shows dashes then.
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= LATCH;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LATCH: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;

endmodule

// File: rtl/seg7_display.sv
// N-digit seven-segment display driver with load handshake.
// A loaded value is converted to BCD, decoded with decimal points,
// optional leading-zero blanking and overflow dashes, then held and
// driven out through a register that also applies per-digit blinking.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   load        : request to display value (accepted when ready=1)
//   value       : unsigned binary value, sampled on accept
//   dp_mask     : per-digit decimal point, sampled on accept
//   blank_lz    : leading-zero blanking, sampled on accept
//   blink_mask  : digits to blink, live
//   ready       : idle, can accept load
//   seg         : DIGITS x {dp,g,f,e,d,c,b,a}, active-low, digit 0 in [7:0]
module seg7_display
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int VAL_W     = 20,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [VAL_W-1:0]      value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  ready,
  output logic [DIGITS*8-1:0]   seg
);

  localparam int SEG_W = 8 * DIGITS;
  localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_LAST   = BL_W'(BLINK_DIV - 1);
  localparam logic [63:0]     OVF_LIMIT = pow10(DIGITS);

  logic                 accept;
  logic                 conv_done;
  logic [4*DIGITS-1:0]  bcd;

  logic                 ovf_q;
  logic                 ovf_d;
  logic [DIGITS-1:0]    dp_q;
  logic                 blank_q;

  logic [SEG_W-1:0]     hold_q;
  logic [SEG_W-1:0]     hold_d;
  logic [SEG_W-1:0]     seg_q;
  logic [SEG_W-1:0]     seg_d;

  logic [BL_W-1:0]      blink_cnt_q;
  logic                 phase_q;

  assign accept = load & ready;

  seg7_bcd_conv #(
    .DIGITS (DIGITS),
    .VAL_W  (VAL_W)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .value_i (value),
    .ready_o (ready),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  assign ovf_d = ({{(64 - VAL_W){1'b0}}, value} >= OVF_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      dp_q    <= '0;
      blank_q <= 1'b0;
    end else if (accept) begin
      ovf_q   <= ovf_d;
      dp_q    <= dp_mask;
      blank_q <= blank_lz;
    end
  end

  // Walk from the most significant digit down so all_zero means
  // "this digit and everything above it is zero".
  always_comb begin
    logic all_zero;
    seg_t code;
    hold_d   = '1;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (bcd[4*i +: 4] == 4'd0);
      if (ovf_q) begin
        code = SEG_DASH;
      end else if (blank_q && (i > 0) && all_zero) begin
        code = SEG_OFF;
      end else begin
        code = seg_decode(bcd[4*i +: 4]);
      end
      if (dp_q[i]) begin
        code[DP_BIT] = 1'b0;
      end
      hold_d[8*i +: 8] = code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '1;
    end else if (conv_done) begin
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    seg_d = hold_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (phase_q && blink_mask[i]) begin
        seg_d[8*i +: 8] = SEG_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;

endmodule

// File: tb/tb_seg7_display.sv
module tb_seg7_display;

  localparam int DIGITS    = 6;
  localparam int VAL_W     = 20;
  localparam int BLINK_DIV = 4;
  localparam int unsigned LIMIT = 1000000;
  localparam logic [7:0] CODES [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 load = 1'b0;
  logic [VAL_W-1:0]     value = '0;
  logic [DIGITS-1:0]    dp_mask = '0;
  logic                 blank_lz = 1'b0;
  logic [DIGITS-1:0]    blink_mask = '0;
  logic                 ready;
  logic [DIGITS*8-1:0]  seg;

  int n_checks = 0;
  int n_errors = 0;
  int edge_k = 0;
  logic [DIGITS*8-1:0] shown = '1;

  seg7_display #(
    .DIGITS    (DIGITS),
    .VAL_W     (VAL_W),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .ready      (ready),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; drives the blink phase model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_k = 0;
    else        edge_k = edge_k + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Display as a person would read it: decimal digits by division.
  function automatic logic [DIGITS*8-1:0] ref_seg(input int unsigned v,
                                                  input logic [DIGITS-1:0] dp,
                                                  input bit blz);
    logic [DIGITS*8-1:0] r;
    logic [7:0] c;
    int unsigned p;
    r = '1;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v >= LIMIT)                c = 8'hBF;
      else if (blz && i > 0 && v < p) c = 8'hFF;
      else                            c = CODES[(v / p) % 10];
      if (dp[i]) c[7] = 1'b0;
      r[8*i +: 8] = c;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check(tag, 64'(ready), 64'd1);
  endtask

  task automatic run_conv(input int unsigned v, input logic [DIGITS-1:0] dp, input bit blz);
    int lo;
    wait_ready("ready_wait");
    @(negedge clk);
    load = 1'b1; value = VAL_W'(v); dp_mask = dp; blank_lz = blz;
    @(posedge clk); #1;
    check("ready_drop", 64'(ready), 64'd0);
    @(negedge clk);
    load = 1'b0;
    value = VAL_W'($urandom); dp_mask = DIGITS'($urandom); blank_lz = 1'($urandom);
    lo = 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) break;
      lo++;
    end
    check("busy_len", 64'(lo), 64'(VAL_W + 1));
    check("seg_old", 64'(seg), 64'(shown));
    @(posedge clk); #1;
    shown = ref_seg(v, dp, blz);
    check("seg_new", 64'(seg), 64'(shown));
  endtask

  initial begin
    int n;
    int unsigned v;
    logic [DIGITS*8-1:0] e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check("rst_ready", 64'(ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("idle_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check("idle_ready", 64'(ready), 64'd1);

    run_conv(123456, 6'b000000, 1'b0);
    check("v123456", 64'(seg), 64'hF9A4_B099_9282);
    run_conv(42, 6'b000000, 1'b1);
    run_conv(0, 6'b000000, 1'b1);
    check("v0_blank", 64'(seg), 64'hFFFF_FFFF_FFC0);
    run_conv(7, 6'b000100, 1'b1);
    check("v7_dp", 64'(seg), 64'hFFFF_FF7F_FFF8);
    run_conv(1000000, 6'b000000, 1'b0);
    run_conv(999999, 6'b000000, 1'b0);
    run_conv(1048575, 6'b100001, 1'b1);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 999999);
        1:       v = $urandom_range(0, 99);
        2:       v = $urandom_range(1000000, 1048575);
        default: v = $urandom_range(0, 9);
      endcase
      run_conv(v, DIGITS'($urandom), 1'($urandom_range(0, 1)));
    end

    // load held high: re-accepted on the first ready cycle
    wait_ready("b2b_wait");
    @(negedge clk);
    load = 1'b1; value = VAL_W'(333333); dp_mask = '0; blank_lz = 1'b0;
    @(posedge clk); #1;
    check("b2b_drop", 64'(ready), 64'd0);
    n = 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) break;
      n++;
    end
    check("b2b_busy", 64'(n), 64'(VAL_W + 1));
    @(posedge clk); #1;
    check("b2b_reaccept", 64'(ready), 64'd0);
    shown = ref_seg(333333, '0, 1'b0);
    check("b2b_seg", 64'(seg), 64'(shown));
    @(negedge clk); load = 1'b0;

    // load while busy is ignored
    wait_ready("busy_wait");
    @(negedge clk);
    load = 1'b1; value = VAL_W'(222222); dp_mask = '0; blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk); value = VAL_W'(111111); dp_mask = '1;
    repeat (9) @(negedge clk);
    load = 1'b0;
    wait_ready("busy_done");
    @(posedge clk); #1;
    shown = ref_seg(222222, '0, 1'b0);
    check("busy_ignore", 64'(seg), 64'(shown));
    repeat (25) @(posedge clk);
    #1;
    check("busy_noqueue_rdy", 64'(ready), 64'd1);
    check("busy_noqueue_seg", 64'(seg), 64'(shown));

    // reset in the middle of a conversion
    wait_ready("rst_wait");
    @(negedge clk);
    load = 1'b1; value = VAL_W'(123456);
    @(posedge clk);
    @(negedge clk); load = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("midrst_seg", 64'(seg), 64'hFFFF_FFFF_FFFF);
    check("midrst_ready", 64'(ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    shown = '1;
    repeat (30) @(posedge clk);
    #1;
    check("midrst_stay", 64'(seg), 64'hFFFF_FFFF_FFFF);

    // blink digit 0
    run_conv(5, 6'b000000, 1'b0);
    @(negedge clk); blink_mask = 6'b000001;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      e = shown;
      if ((((edge_k - 1) / BLINK_DIV) % 2) == 1) e[7:0] = 8'hFF;
      check("blink", 64'(seg), 64'(e));
    end
    @(negedge clk); blink_mask = '0;
    @(posedge clk); #1;
    check("blink_off", 64'(seg), 64'(shown));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
